config_stream_loader: RTL and testbench

- Initiator side of the tile configuration bus: the block that drives config_addr/config_data into every pe_tile in the array.
- Accepts a byte stream (valid/ready) carrying 8-byte frames: 4-byte address, then 4-byte data.
- Issues one configuration write per frame and stops on a terminator frame.
- Sits at the top of the fabric; its config_addr/config_data fan out to all tiles.

---
 rtl/config_stream_loader_if.sv | 44 ++++
 rtl/config_stream_loader.sv | 201 ++++++++++++++++++++
 tb/tb_config_stream_loader.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_stream_loader_if.sv
// ---------------------------------------------------------------------------
// config_stream_loader_if
//   Bundles the stream input, restart strobe and configuration-bus outputs of
//   config_stream_loader.
//   master : stream source / observer  (drives restart, in_valid, in_data)
//   slave  : the loader itself          (drives in_ready, config bus, status)
//   Signals:
//     restart      1        synchronous restart pulse
//     in_valid     1        in_data valid
//     in_ready     1        loader accepts a byte this cycle
//     in_data      8        stream byte
//     config_addr  32       [15:0] tile_id, [31:16] section
//     config_data  32       configuration word
//     busy         1        frame partially collected or write in progress
//     done         1        terminator seen (sticky)
//     frame_count  COUNT_W  writes issued, saturating
//     checksum_err 1        checksum mismatch (sticky, optional feature)
// ---------------------------------------------------------------------------
interface config_stream_loader_if #(
    parameter int unsigned COUNT_W = 16
);
    logic               restart;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;
    logic [31:0]        config_addr;
    logic [31:0]        config_data;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] frame_count;
    logic               checksum_err;

    modport master (
        output restart, in_valid, in_data,
        input  in_ready, config_addr, config_data, busy, done, frame_count,
               checksum_err
    );

    modport slave (
        input  restart, in_valid, in_data,
        output in_ready, config_addr, config_data, busy, done, frame_count,
               checksum_err
    );
endinterface

// File: rtl/config_stream_loader.sv
// ---------------------------------------------------------------------------
// config_stream_loader
//   Initiator of the tile configuration bus. Collects 8-byte frames
//   (address LSB first, then data LSB first) from a valid/ready byte stream
//   and drives each one onto config_addr/config_data for WRITE_CYCLES cycles,
//   followed by at least one idle bus cycle. A frame whose address equals
//   TERM_ADDR ends the stream and is never driven onto the bus.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     cfg    config_stream_loader_if.slave (stream in, restart, bus/status out)
//   Optional feature (macro CONFIG_LOADER_CHECKSUM_EN):
//     after the terminator one extra byte is accepted and compared with the
//     XOR of all frame bytes since reset/restart; a mismatch sets the sticky
//     checksum_err. Without the macro checksum_err is tied low.
// ---------------------------------------------------------------------------
module config_stream_loader #(
    parameter int unsigned WRITE_CYCLES = 1,
    parameter int unsigned COUNT_W      = 16,
    parameter logic [31:0] TERM_ADDR    = 32'hFFFF_FFFF
) (
    input logic                   clk,
    input logic                   rst_n,
    config_stream_loader_if.slave cfg
);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {ST_COLLECT, ST_WRITE, ST_DONE, ST_CHECK} state_e;
`else
    typedef enum logic [1:0] {ST_COLLECT, ST_WRITE, ST_DONE} state_e;
`endif

    // Write hold counter counts down from WRITE_CYCLES-1 to 0.
    localparam logic [3:0] WCNT_LOAD = 4'(WRITE_CYCLES - 1);

    state_e             state_q,    state_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic [55:0]        frame_q,    frame_d;     // bytes 0..6 of the frame
    logic [3:0]         wcnt_q,     wcnt_d;
    logic               in_ready_q, in_ready_d;
    logic [31:0]        addr_q,     addr_d;
    logic [31:0]        data_q,     data_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [COUNT_W-1:0] count_q,    count_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [7:0]         xor_q,      xor_d;
    logic               err_q,      err_d;
`endif

    logic        accept;
    logic [63:0] frame_shift;

    assign accept      = cfg.in_valid && in_ready_q;
    // On the eighth byte this holds the complete frame: [31:0] address,
    // [63:32] data.
    assign frame_shift = {cfg.in_data, frame_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_COLLECT;
            byte_idx_q <= '0;
            frame_q    <= '0;
            wcnt_q     <= '0;
            in_ready_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            xor_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            frame_q    <= frame_d;
            wcnt_q     <= wcnt_d;
            in_ready_q <= in_ready_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        frame_d    = frame_q;
        wcnt_d     = wcnt_q;
        in_ready_d = in_ready_q;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = done_q;
        count_d    = count_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
        err_d      = err_q;
`endif

        if (cfg.restart) begin
            // Restart wins over everything; a byte offered now is not taken.
            state_d    = ST_COLLECT;
            byte_idx_d = '0;
            wcnt_d     = '0;
            in_ready_d = 1'b1;
            addr_d     = '0;
            data_d     = '0;
            done_d     = 1'b0;
            count_d    = '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            xor_d      = '0;
            err_d      = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    in_ready_d = 1'b1;
                    if (accept) begin
                        frame_d    = frame_shift[63:8];
                        byte_idx_d = byte_idx_q + 3'd1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        xor_d      = xor_q ^ cfg.in_data;
`endif
                        if (byte_idx_q == 3'd7) begin
                            if (frame_shift[31:0] == TERM_ADDR) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                                state_d    = ST_CHECK;
`else
                                state_d    = ST_DONE;
                                done_d     = 1'b1;
                                in_ready_d = 1'b0;
`endif
                            end else begin
                                state_d    = ST_WRITE;
                                addr_d     = frame_shift[31:0];
                                data_d     = frame_shift[63:32];
                                wcnt_d     = WCNT_LOAD;
                                in_ready_d = 1'b0;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    in_ready_d = 1'b0;
                    if (wcnt_q == '0) begin
                        state_d    = ST_COLLECT;
                        addr_d     = '0;
                        data_d     = '0;
                        in_ready_d = 1'b1;
                        if (count_q != '1) begin
                            count_d = count_q + 1'b1;
                        end
                    end else begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                end
`ifdef CONFIG_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    in_ready_d = 1'b1;
                    if (accept) begin
                        err_d      = err_q | (cfg.in_data != xor_q);
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                        in_ready_d = 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    in_ready_d = 1'b0;
                end
                default: begin
                    state_d = ST_COLLECT;
                end
            endcase
        end

        // busy is registered, so derive it from the next-state values.
        busy_d = (byte_idx_d != '0) || (state_d == ST_WRITE);
    end

    assign cfg.in_ready    = in_ready_q;
    assign cfg.config_addr = addr_q;
    assign cfg.config_data = data_q;
    assign cfg.busy        = busy_q;
    assign cfg.done        = done_q;
    assign cfg.frame_count = count_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    assign cfg.checksum_err = err_q;
`else
    assign cfg.checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_config_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_config_stream_loader
//   Drives two loaders (WRITE_CYCLES=1 and 3) with directed byte streams and
//   checks every cycle against a frame-level reference model, plus literal
//   expectations at the interesting points. Build with
//   CONFIG_LOADER_CHECKSUM_EN to exercise the checksum byte.
// ---------------------------------------------------------------------------
module tb_config_stream_loader;

    localparam int M_COLLECT = 0;
    localparam int M_WRITE   = 1;
    localparam int M_DONE    = 2;
    localparam int M_CHECK   = 3;

    logic clk;
    logic rst_n;

    logic        in_valid [2];
    logic [7:0]  in_data  [2];
    logic        restart  [2];
    logic        o_ready  [2];
    logic [31:0] o_addr   [2];
    logic [31:0] o_data   [2];
    logic        o_busy   [2];
    logic        o_done   [2];
    logic [15:0] o_cnt    [2];
    logic        o_err    [2];

    int total;
    int bad;

    config_stream_loader_if #(.COUNT_W(16)) bus0 ();
    config_stream_loader_if #(.COUNT_W(16)) bus1 ();

    assign bus0.in_valid = in_valid[0];
    assign bus0.in_data  = in_data[0];
    assign bus0.restart  = restart[0];
    assign bus1.in_valid = in_valid[1];
    assign bus1.in_data  = in_data[1];
    assign bus1.restart  = restart[1];

    assign o_ready[0] = bus0.in_ready;
    assign o_addr[0]  = bus0.config_addr;
    assign o_data[0]  = bus0.config_data;
    assign o_busy[0]  = bus0.busy;
    assign o_done[0]  = bus0.done;
    assign o_cnt[0]   = bus0.frame_count;
    assign o_err[0]   = bus0.checksum_err;
    assign o_ready[1] = bus1.in_ready;
    assign o_addr[1]  = bus1.config_addr;
    assign o_data[1]  = bus1.config_data;
    assign o_busy[1]  = bus1.busy;
    assign o_done[1]  = bus1.done;
    assign o_cnt[1]   = bus1.frame_count;
    assign o_err[1]   = bus1.checksum_err;

    config_stream_loader #(
        .WRITE_CYCLES(1),
        .COUNT_W     (16),
        .TERM_ADDR   (32'hFFFF_FFFF)
    ) u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .cfg  (bus0)
    );

    config_stream_loader #(
        .WRITE_CYCLES(3),
        .COUNT_W     (16),
        .TERM_ADDR   (32'hFFFF_FFFF)
    ) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .cfg  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_ready [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_data  [2];
    logic        m_busy  [2];
    logic        m_done  [2];
    logic [15:0] m_cnt   [2];
    logic        m_err   [2];
    logic [7:0]  m_bytes [2][8];
    logic [7:0]  m_xor   [2];
    int          m_n     [2];
    int          m_mode  [2];
    int          m_hold  [2];

    function automatic int wc_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic model_reset(input int d, input logic rdy);
        m_ready[d] = rdy;
        m_addr[d]  = '0;
        m_data[d]  = '0;
        m_busy[d]  = 1'b0;
        m_done[d]  = 1'b0;
        m_cnt[d]   = '0;
        m_err[d]   = 1'b0;
        m_xor[d]   = '0;
        m_n[d]     = 0;
        m_mode[d]  = M_COLLECT;
        m_hold[d]  = 0;
    endtask

    task automatic model_step(input int d);
        logic        acc;
        logic [31:0] a;
        logic [31:0] w;
        acc = in_valid[d] && m_ready[d];
        if (restart[d]) begin
            model_reset(d, 1'b1);
            return;
        end
        case (m_mode[d])
            M_COLLECT: begin
                m_ready[d] = 1'b1;
                if (acc) begin
                    m_bytes[d][m_n[d]] = in_data[d];
                    m_xor[d] = m_xor[d] ^ in_data[d];
                    m_n[d]++;
                    if (m_n[d] == 8) begin
                        m_n[d] = 0;
                        a = {m_bytes[d][3], m_bytes[d][2], m_bytes[d][1], m_bytes[d][0]};
                        w = {m_bytes[d][7], m_bytes[d][6], m_bytes[d][5], m_bytes[d][4]};
                        if (a == 32'hFFFF_FFFF) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                            m_mode[d] = M_CHECK;
`else
                            m_mode[d]  = M_DONE;
                            m_done[d]  = 1'b1;
                            m_ready[d] = 1'b0;
`endif
                        end else begin
                            m_mode[d]  = M_WRITE;
                            m_hold[d]  = wc_of(d);
                            m_addr[d]  = a;
                            m_data[d]  = w;
                            m_ready[d] = 1'b0;
                        end
                    end
                end
            end
            M_WRITE: begin
                m_hold[d]--;
                if (m_hold[d] == 0) begin
                    m_addr[d]  = '0;
                    m_data[d]  = '0;
                    m_mode[d]  = M_COLLECT;
                    m_ready[d] = 1'b1;
                    if (m_cnt[d] != 16'hFFFF) m_cnt[d] = m_cnt[d] + 16'd1;
                end
            end
            M_CHECK: begin
                if (acc) begin
                    m_err[d]   = m_err[d] | (in_data[d] != m_xor[d]);
                    m_done[d]  = 1'b1;
                    m_mode[d]  = M_DONE;
                    m_ready[d] = 1'b0;
                end
            end
            default: m_ready[d] = 1'b0;
        endcase
        m_busy[d] = (m_n[d] != 0) || (m_mode[d] == M_WRITE);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) model_reset(d, 1'b0);
    end

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) model_reset(d, 1'b0);
            else        model_step(d);
        end
    end

    // ---------------- per-cycle compare + bus log ----------------
    logic [31:0] log_a   [2][8];
    logic [31:0] log_d   [2][8];
    int          log_len [2][8];
    int          log_n   [2];
    logic        was_act [2];
    int          low_cnt [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [83:0] act;
            logic [83:0] exp;
            act = {o_ready[d], o_addr[d], o_data[d], o_busy[d], o_done[d], o_cnt[d], o_err[d]};
            exp = {m_ready[d], m_addr[d], m_data[d], m_busy[d], m_done[d], m_cnt[d], m_err[d]};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL cycle_dut%0d t=%0t: got %h want %h", d, $time, act, exp);
            end
            if (rst_n && !o_ready[d]) low_cnt[d]++;
            if (o_addr[d] != 32'd0) begin
                if (was_act[d] && log_n[d] > 0 && log_a[d][log_n[d]-1] == o_addr[d]) begin
                    log_len[d][log_n[d]-1]++;
                end else if (log_n[d] < 8) begin
                    log_a[d][log_n[d]]   = o_addr[d];
                    log_d[d][log_n[d]]   = o_data[d];
                    log_len[d][log_n[d]] = 1;
                    log_n[d]++;
                end
            end
            was_act[d] = (o_addr[d] != 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] stim [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log(input int d);
        log_n[d]   = 0;
        low_cnt[d] = 0;
    endtask

    // Presents stim[0..n-1] with in_valid held; returns #1 after the edge
    // that took the last byte.
    task automatic send(input int d, input int n);
        logic ok;
        int   waited;
        for (int i = 0; i < n; i++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = stim[i];
            waited = 0;
            ok = 1'b0;
            while (!ok && waited < 100) begin
                @(negedge clk);
                ok = o_ready[d];
                @(posedge clk);
                #1;
                waited++;
            end
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL send_timeout dut%0d byte %0d: got ready=0 want ready=1", d, i);
                break;
            end
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic pulse_restart(input int d);
        restart[d] = 1'b1;
        @(posedge clk);
        #1;
        restart[d] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        total = 0;
        bad   = 0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            in_data[d]  = 8'h00;
            restart[d]  = 1'b0;
            log_n[d]    = 0;
            low_cnt[d]  = 0;
            was_act[d]  = 1'b0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 64'(o_ready[d]), 64'd0);
            check("rst_addr",  64'(o_addr[d]),  64'd0);
            check("rst_data",  64'(o_data[d]),  64'd0);
            check("rst_done",  64'(o_done[d]),  64'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("ready_before_clk", 64'(o_ready[0]), 64'd0);
        idle(1);
        for (int d = 0; d < 2; d++) begin
            check("ready_after_rst", 64'(o_ready[d]), 64'd1);
            check("busy_after_rst",  64'(o_busy[d]),  64'd0);
        end

        // One frame, single write cycle
        stim = '{8'h07, 8'h00, 8'h06, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        clear_log(0);
        send(0, 8);
        check("t1_addr",  64'(o_addr[0]),  64'h0006_0007);
        check("t1_data",  64'(o_data[0]),  64'hDEAD_BEEF);
        check("t1_ready", 64'(o_ready[0]), 64'd0);
        idle(1);
        check("t1_addr_idle", 64'(o_addr[0]), 64'd0);
        check("t1_count",     64'(o_cnt[0]),  64'd1);
        check("t1_ready_back", 64'(o_ready[0]), 64'd1);
        idle(2);
        check("t1_log_n",   64'(log_n[0]),      64'd1);
        check("t1_log_len", 64'(log_len[0][0]), 64'd1);
        check("t1_low",     64'(low_cnt[0]),    64'd1);

        // Two back-to-back frames, three write cycles, in_valid held
        stim = '{8'h07, 8'h00, 8'h06, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                 8'h01, 8'h00, 8'h05, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        clear_log(1);
        send(1, 16);
        idle(6);
        check("t2_log_n",  64'(log_n[1]),      64'd2);
        check("t2_a0",     64'(log_a[1][0]),   64'h0006_0007);
        check("t2_d0",     64'(log_d[1][0]),   64'hDEAD_BEEF);
        check("t2_len0",   64'(log_len[1][0]), 64'd3);
        check("t2_a1",     64'(log_a[1][1]),   64'h0005_0001);
        check("t2_d1",     64'(log_d[1][1]),   64'h1234_5678);
        check("t2_len1",   64'(log_len[1][1]), 64'd3);
        check("t2_low",    64'(low_cnt[1]),    64'd6);
        check("t2_count",  64'(o_cnt[1]),      64'd2);

        // Terminator
        stim = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_log(0);
        send(0, 8);
`ifdef CONFIG_LOADER_CHECKSUM_EN
        check("t3_check_ready", 64'(o_ready[0]), 64'd1);
        check("t3_check_done",  64'(o_done[0]),  64'd0);
        stim = '{8'h23};
        send(0, 1);
`endif
        check("t3_done",  64'(o_done[0]),  64'd1);
        check("t3_ready", 64'(o_ready[0]), 64'd0);
        check("t3_err",   64'(o_err[0]),   64'd0);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h55;
        idle(4);
        in_valid[0] = 1'b0;
        check("t3_count_kept", 64'(o_cnt[0]),  64'd1);
        check("t3_done_kept",  64'(o_done[0]), 64'd1);
        check("t3_no_bus",     64'(log_n[0]),  64'd0);
        pulse_restart(0);
        check("t3_rs_done",  64'(o_done[0]),  64'd0);
        check("t3_rs_count", 64'(o_cnt[0]),   64'd0);
        check("t3_rs_ready", 64'(o_ready[0]), 64'd1);

        // Partial frame discarded by restart; byte offered with restart ignored
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send(0, 5);
        check("t4_busy_partial", 64'(o_busy[0]), 64'd1);
        restart[0]  = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hAA;
        @(posedge clk);
        #1;
        restart[0]  = 1'b0;
        in_valid[0] = 1'b0;
        check("t4_busy_rs", 64'(o_busy[0]), 64'd0);
        stim = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        clear_log(0);
        send(0, 8);
        check("t4_addr", 64'(o_addr[0]), 64'h0004_0001);
        check("t4_data", 64'(o_data[0]), 64'h0000_0001);
        idle(2);
        check("t4_log_n", 64'(log_n[0]), 64'd1);
        check("t4_count", 64'(o_cnt[0]),  64'd1);

        // Terminator after the frame (checksum byte when enabled)
        stim = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        send(0, 8);
`ifdef CONFIG_LOADER_CHECKSUM_EN
        stim = '{8'h04};
        send(0, 1);
        check("t5_err_good",  64'(o_err[0]),  64'd0);
        check("t5_done_good", 64'(o_done[0]), 64'd1);
        pulse_restart(0);
        stim = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        send(0, 16);
        stim = '{8'h05};
        send(0, 1);
        check("t5_err_bad",  64'(o_err[0]),  64'd1);
        check("t5_done_bad", 64'(o_done[0]), 64'd1);
`else
        check("t5_done", 64'(o_done[0]), 64'd1);
        check("t5_err",  64'(o_err[0]),  64'd0);
`endif

        // Asynchronous reset in the middle of a write
        stim = '{8'h07, 8'h00, 8'h06, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send(1, 8);
        check("t6_addr_live", 64'(o_addr[1]), 64'h0006_0007);
        #2 rst_n = 1'b0;
        #1;
        check("t6_addr_rst",  64'(o_addr[1]),  64'd0);
        check("t6_data_rst",  64'(o_data[1]),  64'd0);
        check("t6_ready_rst", 64'(o_ready[1]), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        check("t6_ready", 64'(o_ready[1]), 64'd1);
        check("t6_busy",  64'(o_busy[1]),  64'd0);
        check("t6_count", 64'(o_cnt[1]),   64'd0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
